// File: rtl/audio_fifo_reader_pkg.sv
// Shared types and constants for the audio FIFO read path.
package audio_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIV_W  = 32;
  localparam int DEF_UCNT_W = 16;

  // Shortest legal sample period minus one; leaves room for RD and CAP
  // before the next tick can arrive.
  localparam int MIN_PERIOD = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD,
    CAP
  } state_e;

endpackage

// File: rtl/audio_fifo_reader_if.sv
// Control, FIFO read port and sample outputs of the audio FIFO reader.
// master: the reader itself. slave: the surrounding system (FIFO, software regs, codec).
interface audio_fifo_reader_if #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 32,
  parameter int UCNT_W = 16
);

  logic [DIV_W-1:0]    div_freq;
  logic                pause;
  logic                stop;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_q;
  logic                fifo_rdreq;
  logic [DATA_W/2-1:0] sample_left;
  logic [DATA_W/2-1:0] sample_right;
  logic                sample_valid;
  logic                underflow;
  logic [UCNT_W-1:0]   underflow_cnt;

  modport master (
    input  div_freq, pause, stop, fifo_empty, fifo_q,
    output fifo_rdreq, sample_left, sample_right, sample_valid, underflow, underflow_cnt
  );

  modport slave (
    output div_freq, pause, stop, fifo_empty, fifo_q,
    input  fifo_rdreq, sample_left, sample_right, sample_valid, underflow, underflow_cnt
  );

endinterface

// File: rtl/audio_fifo_reader_rate_tick.sv
// Sample-rate tick generator: counts 0..P with P = max(div_freq, MIN_PERIOD)
// and pulses tick on the last count. The period is captured only on wrap or
// clear, so a div_freq change never shortens the period in flight.
module audio_rate_tick
  import audio_fifo_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_freq_i,
  input  logic             run_i,
  input  logic             clear_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] period_clamped;
  logic             at_end;

  assign period_clamped = (div_freq_i < MIN_P) ? MIN_P : div_freq_i;
  assign at_end         = (count_q == period_q);
  assign tick_o         = run_i && !clear_i && at_end;

  // Next count/period: clear and wrap both reload the period, otherwise count while running.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    count_d  = count_q;
    period_d = period_q;
    if (clear_i) begin
      count_d  = '0;
      period_d = period_clamped;
    end else if (run_i) begin
      if (at_end) begin
        count_d  = '0;
        period_d = period_clamped;
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end
  end

  // Counter and period registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      count_q  <= '0;
      period_q <= MIN_P;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/audio_fifo_reader.sv
// Read side of the Nios audio sample FIFO: pops one stereo word per sample
// period and holds it as left/right samples, honouring pause/stop and
// flagging underflow.
// Optional feature: define AUDIO_FIFO_READER_UCNT_EN to build the saturating
// underflow counter; otherwise underflow_cnt is tied to zero.
// Timing: tick in WAIT -> RD (fifo_rdreq high) -> CAP (fifo_q valid, latched
// at the closing edge) -> new samples and sample_valid presented.
module audio_fifo_reader
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int UCNT_W = DEF_UCNT_W
) (
  input  logic                clk,
  input  logic                reset,
  audio_fifo_reader_if.master bus
);

  localparam int HALF_W = DATA_W / 2;

  state_e            state_q;
  logic              rdreq_q;
  logic [HALF_W-1:0] left_q;
  logic [HALF_W-1:0] right_q;
  logic              valid_q;
  logic              uflow_q;

  logic tick;
  logic cnt_clear;
  logic cnt_run;
  logic uflow_evt;

  // Counter is held at zero while idle or stopped and frozen while paused.
  assign cnt_clear = bus.stop || (state_q == IDLE);
  assign cnt_run   = !bus.pause;

  // A period elapsed with nothing to pop; tick is already suppressed by stop.
  assign uflow_evt = (state_q == WAIT) && tick && bus.fifo_empty;

  audio_rate_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .div_freq_i (bus.div_freq),
    .run_i      (cnt_run),
    .clear_i    (cnt_clear),
    .tick_o     (tick)
  );

  // Playback FSM with registered strobes, sample holding and the sticky underflow flag.
  // Pause is only looked at in IDLE (entry) and via the frozen tick, so a
  // pop started in RD always completes through CAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdreq_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      rdreq_q <= 1'b0;
      valid_q <= 1'b0;
      if (bus.stop) begin
        state_q <= IDLE;
        left_q  <= '0;
        right_q <= '0;
        uflow_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!bus.pause) state_q <= WAIT;
          end
          WAIT: begin
            if (tick) begin
              if (!bus.fifo_empty) begin
                state_q <= RD;
                rdreq_q <= 1'b1;
              end else begin
                uflow_q <= 1'b1;
              end
            end
          end
          RD: begin
            state_q <= CAP;
          end
          CAP: begin
            left_q  <= bus.fifo_q[DATA_W-1:HALF_W];
            right_q <= bus.fifo_q[HALF_W-1:0];
            valid_q <= 1'b1;
            state_q <= WAIT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef AUDIO_FIFO_READER_UCNT_EN
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  logic [UCNT_W-1:0] ucnt_q;

  // Saturating count of underflow periods, cleared by stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt_q <= '0;
    end else if (bus.stop) begin
      ucnt_q <= '0;
    end else if (uflow_evt && (ucnt_q != UCNT_MAX)) begin
      ucnt_q <= ucnt_q + UCNT_W'(1);
    end
  end

  assign bus.underflow_cnt = ucnt_q;
`else
  logic unused_uflow_evt;
  assign unused_uflow_evt  = uflow_evt;
  assign bus.underflow_cnt = {UCNT_W{1'b0}};
`endif

  assign bus.fifo_rdreq   = rdreq_q;
  assign bus.sample_left  = left_q;
  assign bus.sample_right = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.underflow    = uflow_q;

endmodule
